regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 83 ++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: three-way round-robin writeback arbiter with one holding buffer per requester
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        in_valid,
  input  logic [ADDR_W-1:0] in_addr0,
  input  logic [ADDR_W-1:0] in_addr1,
  input  logic [ADDR_W-1:0] in_addr2,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [DATA_W-1:0] in_data2,
  output logic [2:0]        in_ready,
  input  logic              flush,
  output logic              wb_en,
  output logic [1:0]        wb_sel,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [2:0]        pending
);
  logic [ADDR_W-1:0] in_a [3];
  logic [DATA_W-1:0] in_d [3];
  logic [ADDR_W-1:0] addr_q [3];
  logic [DATA_W-1:0] data_q [3];
  logic [1:0]        last_grant, s0, s1, s2, gidx;
  logic [2:0]        gnt, acc, nz;
  logic              gv;
  assign in_a = '{in_addr0, in_addr1, in_addr2};
  assign in_d = '{in_data0, in_data1, in_data2};
  // Search order starts just after the last winner and wraps mod 3
  always_comb begin
    s0 = last_grant == 2'd2 ? 2'd0 : last_grant + 2'd1;
    s1 = s0 == 2'd2 ? 2'd0 : s0 + 2'd1;
    s2 = s1 == 2'd2 ? 2'd0 : s1 + 2'd1;
    gv = |pending;
    gidx = pending[s0] ? s0 : pending[s1] ? s1 : s2;
    gnt = gv ? 3'b001 << gidx : 3'b000;
    nz = {in_addr2 != '0, in_addr1 != '0, in_addr0 != '0};
  end
  assign in_ready = rst ? 3'b111 : (~pending | gnt) & {3{~flush}};
  assign acc = in_valid & in_ready;
  // Holding buffers capture accepted requests; r0 writes are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++)
        if (acc[i] && nz[i]) begin
          addr_q[i] <= in_a[i];
          data_q[i] <= in_d[i];
        end
    end
  end
  // Occupancy, grant pointer and registered write port; flush overrides everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      wb_en      <= 1'b0;
      wb_sel     <= 2'd0;
      wb_addr    <= '0;
      wb_data    <= '0;
      last_grant <= 2'd2;
    end else if (flush) begin
      pending <= '0;
      wb_en   <= 1'b0;
      wb_sel  <= 2'd0;
    end else begin
      pending <= (pending & ~gnt) | (acc & nz);
      wb_en   <= gv;
      wb_sel  <= gv ? gidx : 2'd0;
      if (gv) begin
        wb_addr    <= addr_q[gidx];
        wb_data    <= data_q[gidx];
        last_grant <= gidx;
      end
    end
  end
endmodule
